jt51_prog_seq: RTL and testbench

Register-programming sequencer for the jt51 core. It replaces ad-hoc bench stimulus with a synthesizable controller. It fetches a command list from a synchronous program memory and issues YM2151 address/data bus writes, polling the core busy flag before each write. Once the list ends it raises `prog_done`. It then watches the left output and raises `silent` after a configurable run of zero samples.

---
 rtl/jt51_prog_seq.sv | 89 ++++++++
 tb/tb_jt51_prog_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_prog_seq.sv
// jt51_prog_seq: replays a register-write/wait command list from program memory into the
// jt51 bus, then flags a run of SIL_N zero left samples as silence.
`timescale 1ns/1ps
module jt51_prog_seq #(
    parameter int AW    = 10,
    parameter int SIL_N = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] prog_addr,
    input  logic [17:0]   prog_data,
    output logic          cs_n,
    output logic          wr_n,
    output logic          a0,
    output logic [7:0]    din,
    input  logic [7:0]    dout,
    input  logic          sample,
    input  logic [15:0]   left,
    output logic          running,
    output logic          prog_done,
    output logic          silent
);
    localparam int SW = $clog2(SIL_N + 1);
    typedef enum logic [3:0] {IDLE, FETCH, DECODE, POLL, CHK, WA, GA, WD, GD, WAIT, DONE} state_t;
    state_t st, st_nx;
    logic [7:0] rg, dt;
    logic [15:0] wcnt;
    logic [SW-1:0] sil_cnt;
    logic go, last, unused_ok;
    assign go = start && (st == IDLE || st == DONE);
    assign last = &prog_addr;
    assign unused_ok = ^dout[6:0];
    // The last address ends the run rather than wrapping back to 0
    always_comb begin
        st_nx = st;
        case (st)
            IDLE, DONE: st_nx = start ? FETCH : st;
            FETCH:      st_nx = DECODE;
            DECODE:     st_nx = prog_data[17] ? DONE : !prog_data[16] ? POLL :
                                |prog_data[15:0] ? WAIT : last ? DONE : FETCH;
            POLL:       st_nx = CHK;
            CHK:        st_nx = dout[7] ? POLL : WA;
            WA:         st_nx = GA;
            GA:         st_nx = WD;
            WD:         st_nx = GD;
            GD:         st_nx = last ? DONE : FETCH;
            WAIT:       st_nx = wcnt == 16'd1 ? (last ? DONE : FETCH) : WAIT;
            default:    st_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            prog_addr <= '0;
            rg        <= '0;
            dt        <= '0;
            wcnt      <= '0;
            cs_n      <= 1'b1;
            wr_n      <= 1'b1;
            a0        <= 1'b0;
            din       <= '0;
            running   <= 1'b0;
            prog_done <= 1'b0;
        end else begin
            st        <= st_nx;
            prog_addr <= go ? '0 : (st_nx == FETCH && st != IDLE && st != DONE) ? prog_addr + 1'b1 : prog_addr;
            rg        <= st == DECODE ? prog_data[15:8] : rg;
            dt        <= st == DECODE ? prog_data[7:0] : dt;
            wcnt      <= st == DECODE ? prog_data[15:0] : st == WAIT ? wcnt - 1'b1 : wcnt;
            // Bus pins follow the state being entered so they are registered yet aligned with it
            cs_n      <= !(st_nx == POLL || st_nx == WA || st_nx == WD);
            wr_n      <= !(st_nx == WA || st_nx == WD);
            a0        <= st_nx == POLL || st_nx == WD;
            din       <= st_nx == WA ? rg : st_nx == WD ? dt : din;
            running   <= !(st_nx == IDLE || st_nx == DONE);
            prog_done <= st_nx == DONE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst || go) begin
            sil_cnt <= '0;
            silent  <= 1'b0;
        end else if (prog_done) begin
            sil_cnt <= !sample ? sil_cnt : |left ? '0 : sil_cnt == SW'(SIL_N) ? sil_cnt : sil_cnt + 1'b1;
            silent  <= silent | (sil_cnt == SW'(SIL_N));
        end
    end
endmodule

// File: tb/tb_jt51_prog_seq.sv
// tb_jt51_prog_seq: expands each program into a per-cycle bus timeline from the latency rules
// and compares both sequencer instances against it, plus literal cycle pins.
`timescale 1ns/1ps
module tb_jt51_prog_seq;
    logic clk = 0, rst = 1, start = 0, start2 = 0, sample = 0;
    logic [15:0] left = 0;
    logic [7:0] dout;
    logic [17:0] pd, pd2;
    logic [17:0] mem [1024];
    logic [17:0] mem2 [4];
    logic [9:0] pa;
    logic [1:0] pa2;
    logic cs, wr, a0, run, done, sil, cs2, wr2, a02, run2, done2, sil2;
    logic [7:0] din, din2;

    typedef struct packed {
        logic cs_n, wr_n, a0;
        logic [7:0] din;
        logic running, done;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    logic cur_sil;
    bit sel = 0;
    int checks = 0, errors = 0;
    int busy_n = 0, poll_cnt = 0;
    int cyc = 0, first_cs = -1, wa_cyc = -1, wd_cyc = -1, done_cyc = -1, nwr = 0;

    jt51_prog_seq dut (.clk(clk), .rst(rst), .start(start), .prog_addr(pa), .prog_data(pd),
        .cs_n(cs), .wr_n(wr), .a0(a0), .din(din), .dout(dout), .sample(sample), .left(left),
        .running(run), .prog_done(done), .silent(sil));
    jt51_prog_seq #(.AW(2), .SIL_N(4)) dut2 (.clk(clk), .rst(rst), .start(start2), .prog_addr(pa2),
        .prog_data(pd2), .cs_n(cs2), .wr_n(wr2), .a0(a02), .din(din2), .dout(dout), .sample(sample),
        .left(left), .running(run2), .prog_done(done2), .silent(sil2));

    always #5 clk = ~clk;
    always @(posedge clk) begin
        pd  <= mem[pa];
        pd2 <= mem2[pa2];
    end
    assign cur = sel ? {cs2, wr2, a02, din2, run2, done2} : {cs, wr, a0, din, run, done};
    assign cur_sil = sel ? sil2 : sil;
    // Busy is reported for the first busy_n status reads of a run
    assign dout = {poll_cnt <= busy_n, 7'd0};
    always @(negedge clk) if (!cur.cs_n && cur.wr_n && cur.a0) poll_cnt++;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            cyc++;
            e = q.pop_front();
            chk("cs_n", cur.cs_n, e.cs_n);
            chk("wr_n", cur.wr_n, e.wr_n);
            if (!e.cs_n) chk("a0", cur.a0, e.a0);
            if (!e.wr_n) chk("din", cur.din, e.din);
            chk("running", cur.running, e.running);
            chk("prog_done", cur.done, e.done);
            chk("silent_run", cur_sil, 0);
            if (!cur.cs_n && first_cs < 0) first_cs = cyc;
            if (!cur.wr_n && !cur.a0 && wa_cyc < 0) wa_cyc = cyc;
            if (!cur.wr_n && cur.a0) begin
                nwr++;
                if (wd_cyc < 0) wd_cyc = cyc;
            end
            if (cur.done && done_cyc < 0) done_cyc = cyc;
        end
    end

    // Expected bus activity per cycle, cycle 1 being the first after start is taken
    task automatic build(input int aw);
        exp_t idle_e = '{1, 1, 0, 8'h00, 1, 0};
        logic [17:0] w;
        int a = 0, first = 1, polls;
        q.delete();
        for (int g = 0; g < 64; g++) begin
            w = sel ? mem2[a[1:0]] : mem[a[9:0]];
            q.push_back(idle_e);
            q.push_back(idle_e);
            if (w[17]) break;
            if (!w[16]) begin
                polls = first ? busy_n + 1 : 1;
                first = 0;
                repeat (polls) begin
                    q.push_back('{0, 1, 1, 8'h00, 1, 0});
                    q.push_back(idle_e);
                end
                q.push_back('{0, 0, 0, w[15:8], 1, 0});
                q.push_back(idle_e);
                q.push_back('{0, 0, 1, w[7:0], 1, 0});
                q.push_back(idle_e);
            end else repeat (int'(w[15:0])) q.push_back(idle_e);
            if (a == (1 << aw) - 1) break;
            a++;
        end
        q.push_back('{1, 1, 0, 8'h00, 0, 1});
    endtask

    task automatic go(input int aw, input bit smp);
        @(negedge clk);
        build(aw);
        cyc = 0; first_cs = -1; wa_cyc = -1; wd_cyc = -1; done_cyc = -1; nwr = 0; poll_cnt = 0;
        if (sel) start2 = 1; else start = 1;
        sample = smp;
        left = 0;
        @(negedge clk);
        start = 0;
        start2 = 0;
        sample = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && q.size() > 0; i++) @(posedge clk);
        #3;
        chk("run_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic feed(input int n, input logic [15:0] lv);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample = 1;
            left = lv;
        end
        @(negedge clk);
        sample = 0;
        left = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_write_prog();
        mem[0] = {2'b00, 8'h20, 8'hC7};
        mem[1] = {2'b10, 16'h0000};
    endtask

    initial begin
        load_write_prog();
        mem2[0] = {2'b00, 8'h30, 8'h01};
        mem2[1] = {2'b00, 8'h31, 8'h02};
        mem2[2] = {2'b00, 8'h32, 8'h03};
        mem2[3] = {2'b00, 8'h33, 8'h04};
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs, 1); chk("rst_wr_n", wr, 1); chk("rst_a0", a0, 0);
        chk("rst_din", din, 0); chk("rst_addr", pa, 0); chk("rst_running", run, 0);
        chk("rst_done", done, 0); chk("rst_silent", sil, 0); chk("rst_cs_n2", cs2, 1);
        rst = 0;

        // single write, busy clear, with a start pulse mid-run that must be ignored
        go(10, 0);
        repeat (2) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done();
        chk("w_first_cs", first_cs, 3); chk("w_wa_cyc", wa_cyc, 5);
        chk("w_wd_cyc", wd_cyc, 7); chk("w_done_cyc", done_cyc, 11); chk("w_nwr", nwr, 1);

        // five busy polls delay the address strobe by 10 clk
        busy_n = 5;
        go(10, 0);
        wait_done();
        chk("b_wa_cyc", wa_cyc, 15); chk("b_done_cyc", done_cyc, 21); chk("b_polls", poll_cnt, 6);
        busy_n = 0;

        feed(2047, 0);
        chk("sil_2047", sil, 0);
        feed(1, 0);
        chk("sil_2048", sil, 1);

        // a nonzero sample restarts the run of zeros
        go(10, 0);
        wait_done();
        feed(999, 0);
        feed(1, 16'h0001);
        feed(2047, 0);
        chk("sil_restart_2047", sil, 0);
        feed(1, 0);
        chk("sil_restart_2048", sil, 1);

        // waits only; a sample coinciding with start must not survive the clear
        feed(2047, 0);
        mem[0] = {2'b01, 16'h0003};
        mem[1] = {2'b01, 16'h0000};
        mem[2] = {2'b10, 16'h0000};
        go(10, 1);
        wait_done();
        chk("wait_first_cs", first_cs, -1); chk("wait_done_cyc", done_cyc, 10);
        feed(1, 0);
        chk("sil_after_clear", sil, 0);
        feed(2047, 0);
        chk("sil_after_clear_full", sil, 1);

        // reset during the data strobe, then replay from address 0
        load_write_prog();
        go(10, 0);
        repeat (6) @(negedge clk);
        chk("in_wd_wr_n", wr, 0); chk("in_wd_a0", a0, 1);
        rst = 1;
        q.delete();
        @(posedge clk);
        #2;
        chk("rst_wd_cs_n", cs, 1); chk("rst_wd_wr_n", wr, 1);
        chk("rst_wd_addr", pa, 0); chk("rst_wd_running", run, 0);
        @(negedge clk);
        rst = 0;
        go(10, 0);
        wait_done();
        chk("replay_done_cyc", done_cyc, 11);

        // AW=2 memory full of writes: ends at the last address instead of wrapping
        sel = 1;
        go(2, 0);
        wait_done();
        chk("full_nwr", nwr, 4); chk("full_done_cyc", done_cyc, 33);
        chk("full_addr", pa2, 3);
        repeat (3) @(negedge clk);
        chk("full_no_wrap_cs", cs2, 1); chk("full_done_sticky", done2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
